// File: rtl/touch_button_array.sv
`default_nettype none
// ============================================================================
//  Module   : touch_button_array
//  Purpose  : Hit-tests touch coordinates against N_BTN runtime-programmable
//             rectangles, debounces the winning button and reports a held
//             level, one-clk press/release pulses and the held button index.
//  Ports    : clk, reset (async, active-low), enable, clcount (sample phase),
//             touch_down, tor_x, tor_y             - touch controller side
//             rect_x_lo/hi, rect_y_lo/hi, btn_mask - packed button geometry
//             btn_hit, btn_held, btn_press, btn_release, btn_id, any_held
//  Revision : 1.0 - initial release
// ============================================================================
module touch_button_array #(
    parameter int N_BTN        = 4,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int SAMPLE_PHASE = 1,
    parameter int PRESS_CNT    = 3,
    parameter int REL_CNT      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           clcount,
    input  logic                 touch_down,
    input  logic [X_W-1:0]       tor_x,
    input  logic [Y_W-1:0]       tor_y,
    input  logic [N_BTN*X_W-1:0] rect_x_lo,
    input  logic [N_BTN*X_W-1:0] rect_x_hi,
    input  logic [N_BTN*Y_W-1:0] rect_y_lo,
    input  logic [N_BTN*Y_W-1:0] rect_y_hi,
    input  logic [N_BTN-1:0]     btn_mask,
    output logic [N_BTN-1:0]     btn_hit,
    output logic [N_BTN-1:0]     btn_held,
    output logic [N_BTN-1:0]     btn_press,
    output logic [N_BTN-1:0]     btn_release,
    output logic [3:0]           btn_id,
    output logic                 any_held
);

    localparam logic [1:0] c_sample_phase = 2'(SAMPLE_PHASE);
    localparam logic [3:0] c_press_cnt    = 4'(PRESS_CNT);
    localparam logic [3:0] c_rel_cnt      = 4'(REL_CNT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HELD = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cur;
    logic [3:0]       r_cnt;
    logic [N_BTN-1:0] r_hit;
    logic [N_BTN-1:0] r_held;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_release;

    logic             w_sample;
    logic [N_BTN-1:0] w_raw;
    logic [N_BTN-1:0] w_win_oh;
    logic [N_BTN-1:0] w_cur_oh;
    logic [3:0]       w_win_idx;
    logic             w_any;
    logic [3:0]       w_cnt_inc;

    assign w_sample  = (clcount == c_sample_phase);
    assign w_cnt_inc = (r_cnt == 4'hF) ? 4'hF : (r_cnt + 4'd1);

    // Inclusive unsigned rectangle test; lo > hi can never satisfy both
    // bounds, so degenerate rectangles drop out without extra logic.
    for (genvar i = 0; i < N_BTN; i++) begin : g_hit
        assign w_raw[i] = touch_down & btn_mask[i]
                        & (tor_x >= rect_x_lo[i*X_W +: X_W])
                        & (tor_x <= rect_x_hi[i*X_W +: X_W])
                        & (tor_y >= rect_y_lo[i*Y_W +: Y_W])
                        & (tor_y <= rect_y_hi[i*Y_W +: Y_W]);
        assign w_cur_oh[i] = (r_cur == 4'(i));
    end

    // Overlap priority: walk from the top so the lowest index is kept last.
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = 4'd0;
        w_win_oh  = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (w_raw[i]) begin
                w_any       = 1'b1;
                w_win_idx   = 4'(i);
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cur     <= 4'd0;
            r_cnt     <= 4'd0;
            r_hit     <= '0;
            r_held    <= '0;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_press   <= '0;
            r_release <= '0;
            if (!enable) begin
                // Leaving HELD through a disable still tells the UI the
                // button went away; other states just drop to idle.
                if (r_state == S_HELD) begin
                    r_release <= r_held;
                end
                r_state <= S_IDLE;
                r_cur   <= 4'd0;
                r_cnt   <= 4'd0;
                r_hit   <= '0;
                r_held  <= '0;
            end else if (w_sample) begin
                r_hit <= w_win_oh;
                case (r_state)
                    S_IDLE: begin
                        if (w_any) begin
                            r_cur <= w_win_idx;
                            if (PRESS_CNT == 1) begin
                                r_state <= S_HELD;
                                r_cnt   <= 4'd0;
                                r_held  <= w_win_oh;
                                r_press <= w_win_oh;
                            end else begin
                                r_state <= S_ARM;
                                r_cnt   <= 4'd1;
                            end
                        end
                    end
                    S_ARM: begin
                        if (!w_any) begin
                            r_state <= S_IDLE;
                            r_cnt   <= 4'd0;
                        end else if (w_win_idx == r_cur) begin
                            if (w_cnt_inc >= c_press_cnt) begin
                                r_state <= S_HELD;
                                r_cnt   <= 4'd0;
                                r_held  <= w_win_oh;
                                r_press <= w_win_oh;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            // A different button restarts the debounce.
                            r_cur <= w_win_idx;
                            r_cnt <= 4'd1;
                        end
                    end
                    S_HELD: begin
                        if (w_any && (w_win_idx == r_cur)) begin
                            r_cnt <= 4'd0;
                        end else if (w_cnt_inc >= c_rel_cnt) begin
                            // Another button is only armed on a later sample.
                            r_state   <= S_IDLE;
                            r_cnt     <= 4'd0;
                            r_held    <= '0;
                            r_release <= w_cur_oh;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= 4'd0;
                        r_held  <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_hit     = r_hit;
    assign btn_held    = r_held;
    assign btn_press   = r_press;
    assign btn_release = r_release;
    assign any_held    = |r_held;
    assign btn_id      = (r_state == S_HELD) ? r_cur : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_touch_button_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_touch_button_array
//  Purpose  : Randomised and directed stimulus for touch_button_array with a
//             queue-based scoreboard fed by a button-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_touch_button_array;

    localparam int         N_BTN        = 4;
    localparam int         X_W          = 10;
    localparam int         Y_W          = 9;
    localparam int         SAMPLE_PHASE = 1;
    localparam int         PRESS_CNT    = 3;
    localparam int         REL_CNT      = 2;
    localparam logic [1:0] SPH          = 2'(SAMPLE_PHASE);

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic [1:0]           clcount;
    logic                 touch_down;
    logic [X_W-1:0]       tor_x;
    logic [Y_W-1:0]       tor_y;
    logic [N_BTN*X_W-1:0] rect_x_lo;
    logic [N_BTN*X_W-1:0] rect_x_hi;
    logic [N_BTN*Y_W-1:0] rect_y_lo;
    logic [N_BTN*Y_W-1:0] rect_y_hi;
    logic [N_BTN-1:0]     btn_mask;
    logic [N_BTN-1:0]     btn_hit;
    logic [N_BTN-1:0]     btn_held;
    logic [N_BTN-1:0]     btn_press;
    logic [N_BTN-1:0]     btn_release;
    logic [3:0]           btn_id;
    logic                 any_held;

    logic [X_W-1:0] rxl [N_BTN];
    logic [X_W-1:0] rxh [N_BTN];
    logic [Y_W-1:0] ryl [N_BTN];
    logic [Y_W-1:0] ryh [N_BTN];

    always_comb begin
        rect_x_lo = {rxl[3], rxl[2], rxl[1], rxl[0]};
        rect_x_hi = {rxh[3], rxh[2], rxh[1], rxh[0]};
        rect_y_lo = {ryl[3], ryl[2], ryl[1], ryl[0]};
        rect_y_hi = {ryh[3], ryh[2], ryh[1], ryh[0]};
    end

    touch_button_array #(
        .N_BTN(N_BTN), .X_W(X_W), .Y_W(Y_W), .SAMPLE_PHASE(SAMPLE_PHASE),
        .PRESS_CNT(PRESS_CNT), .REL_CNT(REL_CNT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clcount(clcount),
        .touch_down(touch_down), .tor_x(tor_x), .tor_y(tor_y),
        .rect_x_lo(rect_x_lo), .rect_x_hi(rect_x_hi),
        .rect_y_lo(rect_y_lo), .rect_y_hi(rect_y_hi),
        .btn_mask(btn_mask), .btn_hit(btn_hit), .btn_held(btn_held),
        .btn_press(btn_press), .btn_release(btn_release),
        .btn_id(btn_id), .any_held(any_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (button-level view) -----------------
    typedef struct {
        logic [3:0] hit;
        logic [3:0] held;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] id;
        logic [3:0] any;
    } exp_t;

    exp_t sb[$];

    int         m_held   = -1;  // button currently held, -1 = none
    int         m_cand   = -1;  // button whose consecutive hits are counted
    int         m_streak = 0;
    int         m_miss   = 0;
    logic [3:0] m_hit    = '0;
    logic [3:0] m_press  = '0;
    logic [3:0] m_rel    = '0;

    function automatic logic [3:0] oh(input int i);
        if (i < 0) return 4'd0;
        return 4'(1 << i);
    endfunction

    function automatic int winner();
        if (!touch_down) return -1;
        for (int i = 0; i < N_BTN; i++) begin
            if (btn_mask[i] && rxl[i] <= tor_x && tor_x <= rxh[i]
                            && ryl[i] <= tor_y && tor_y <= ryh[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        int w;
        exp_t e;
        m_press = '0;
        m_rel   = '0;
        if (!reset) begin
            m_held = -1; m_cand = -1; m_streak = 0; m_miss = 0; m_hit = '0;
        end else if (!enable) begin
            m_rel  = oh(m_held);
            m_held = -1; m_cand = -1; m_streak = 0; m_miss = 0; m_hit = '0;
        end else if (clcount == SPH) begin
            w     = winner();
            m_hit = oh(w);
            if (m_held >= 0) begin
                if (w == m_held) m_miss = 0;
                else m_miss++;
                if (m_miss >= REL_CNT) begin
                    m_rel  = oh(m_held);
                    m_held = -1; m_miss = 0; m_cand = -1; m_streak = 0;
                end
            end else begin
                if (w < 0) begin
                    m_cand = -1; m_streak = 0;
                end else if (w == m_cand) begin
                    m_streak++;
                end else begin
                    m_cand = w; m_streak = 1;
                end
                if (m_cand >= 0 && m_streak >= PRESS_CNT) begin
                    m_held  = m_cand;
                    m_press = oh(m_cand);
                    m_cand  = -1; m_streak = 0; m_miss = 0;
                end
            end
        end
        e.hit   = m_hit;
        e.held  = oh(m_held);
        e.press = m_press;
        e.rel   = m_rel;
        e.id    = (m_held >= 0) ? 4'(m_held) : 4'd0;
        e.any   = (m_held >= 0) ? 4'd1 : 4'd0;
        sb.push_back(e);
    endtask

    // ---------------- monitor ---------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_hit",     btn_hit,             e.hit);
                chk("sb_held",    btn_held,            e.held);
                chk("sb_press",   btn_press,           e.press);
                chk("sb_release", btn_release,         e.rel);
                chk("sb_id",      btn_id,              e.id);
                chk("sb_any",     {3'b000, any_held},  e.any);
            end
        end
    end

    // ---------------- stimulus helpers --------------------------------------
    task automatic step(input logic r, input logic en, input logic [1:0] ph,
                        input logic td, input int x, input int y);
        reset      = r;
        enable     = en;
        clcount    = ph;
        touch_down = td;
        tor_x      = X_W'(x);
        tor_y      = Y_W'(y);
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [1:0] nsph();
        return SPH + 2'($urandom_range(1, 3));
    endfunction

    // Zero to two non-sample cycles, then one sample cycle.
    task automatic samp(input logic td, input int x, input int y);
        repeat ($urandom_range(0, 2)) step(1'b1, 1'b1, nsph(), td, x, y);
        step(1'b1, 1'b1, SPH, td, x, y);
    endtask

    task automatic idle_samples(input int n);
        repeat (n) samp(1'b0, 0, 0);
    endtask

    task automatic set_rect(input int i, input int xl, input int xh, input int yl, input int yh);
        rxl[i] = X_W'(xl); rxh[i] = X_W'(xh);
        ryl[i] = Y_W'(yl); ryh[i] = Y_W'(yh);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        int px, py;
        logic ptd;
        set_rect(0, 210, 288, 301, 380);
        set_rect(1, 406, 495, 301, 380);
        set_rect(2, 50, 150, 50, 150);
        set_rect(3, 80, 200, 60, 200);
        btn_mask = 4'hF;
        reset = 1'b0; enable = 1'b1; clcount = SPH; touch_down = 1'b1;
        tor_x = X_W'(250); tor_y = Y_W'(340);
        @(negedge clk);

        // Reset held with an active touch on btn0
        repeat (3) step(1'b0, 1'b1, SPH, 1'b1, 250, 340);
        chk("rst_hit",  btn_hit,  4'b0000);
        chk("rst_held", btn_held, 4'b0000);
        chk("rst_any",  {3'b000, any_held}, 4'b0000);
        step(1'b1, 1'b1, nsph(), 1'b0, 0, 0);
        idle_samples(2);
        chk("idle_held", btn_held, 4'b0000);

        // Basic press / release on btn0
        samp(1'b1, 250, 340);
        chk("basic_hit1", btn_hit, 4'b0001);
        samp(1'b1, 250, 340);
        chk("basic_nopress2", btn_press, 4'b0000);
        samp(1'b1, 250, 340);
        chk("basic_press", btn_press, 4'b0001);
        chk("basic_held",  btn_held,  4'b0001);
        chk("basic_id",    btn_id,    4'd0);
        chk("basic_any",   {3'b000, any_held}, 4'b0001);
        step(1'b1, 1'b1, nsph(), 1'b1, 250, 340);
        chk("basic_press_clr", btn_press, 4'b0000);
        samp(1'b0, 0, 0);
        chk("basic_held_1miss", btn_held, 4'b0001);
        samp(1'b0, 0, 0);
        chk("basic_release", btn_release, 4'b0001);
        chk("basic_unheld",  btn_held,    4'b0000);

        // Edge inclusivity
        samp(1'b1, 210, 301); chk("edge_210_301", btn_hit, 4'b0001);
        samp(1'b1, 288, 380); chk("edge_288_380", btn_hit, 4'b0001);
        samp(1'b1, 406, 380); chk("edge_406_380", btn_hit, 4'b0010);
        samp(1'b1, 209, 301); chk("edge_209_301", btn_hit, 4'b0000);
        samp(1'b1, 289, 381); chk("edge_289_381", btn_hit, 4'b0000);
        idle_samples(2);

        // Debounce bounce on btn1: in, in, out, in, in, in
        begin
            logic [5:0] pat = 6'b111011;  // bit k = sample k is inside
            for (int k = 0; k < 6; k++) begin
                samp(pat[k], 450, 340);
                chk("bounce_press", btn_press, (k == 5) ? 4'b0010 : 4'b0000);
            end
        end
        idle_samples(2);

        // Overlap priority and masking
        samp(1'b1, 100, 100); chk("ovl_hit", btn_hit, 4'b0100);
        samp(1'b1, 100, 100);
        samp(1'b1, 100, 100); chk("ovl_press", btn_press, 4'b0100);
        idle_samples(2);
        btn_mask = 4'b1011;
        samp(1'b1, 100, 100); chk("mask_hit", btn_hit, 4'b1000);
        samp(1'b1, 100, 100);
        samp(1'b1, 100, 100); chk("mask_press", btn_press, 4'b1000);
        chk("mask_id", btn_id, 4'd3);
        idle_samples(2);
        btn_mask = 4'hF;

        // Slide from btn0 to btn1
        repeat (3) samp(1'b1, 250, 340);
        samp(1'b1, 450, 340); chk("slide_held", btn_held, 4'b0001);
        samp(1'b1, 450, 340); chk("slide_rel", btn_release, 4'b0001);
        samp(1'b1, 450, 340); chk("slide_arm1", btn_press, 4'b0000);
        samp(1'b1, 450, 340); chk("slide_arm2", btn_press, 4'b0000);
        samp(1'b1, 450, 340); chk("slide_press", btn_press, 4'b0010);

        // Disable while btn1 held
        step(1'b1, 1'b0, nsph(), 1'b1, 450, 340);
        chk("dis_rel",  btn_release, 4'b0010);
        chk("dis_held", btn_held,    4'b0000);
        chk("dis_hit",  btn_hit,     4'b0000);
        step(1'b1, 1'b1, nsph(), 1'b1, 450, 340);
        chk("dis_rel_clr", btn_release, 4'b0000);

        // Reset in the middle of arming
        samp(1'b1, 250, 340);
        samp(1'b1, 250, 340);
        step(1'b0, 1'b1, SPH, 1'b1, 250, 340);
        chk("midrst_press", btn_press,   4'b0000);
        chk("midrst_rel",   btn_release, 4'b0000);
        chk("midrst_hit",   btn_hit,     4'b0000);
        step(1'b1, 1'b1, nsph(), 1'b0, 0, 0);
        idle_samples(2);

        // Degenerate rectangle (lo > hi) never hits
        set_rect(3, 300, 250, 395, 390);
        samp(1'b1, 275, 392); chk("degen_hit", btn_hit, 4'b0000);
        idle_samples(1);
        set_rect(3, 80, 200, 60, 200);

        // Randomised traffic
        px = 250; py = 340; ptd = 1'b1;
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                case ($urandom_range(0, 6))
                    0: begin px = 250; py = 340; end
                    1: begin px = 450; py = 340; end
                    2: begin px = 100; py = 100; end
                    3: begin px = 180; py = 180; end
                    4: begin px = 600; py = 450; end
                    5: begin px = $urandom_range(200, 300); py = $urandom_range(295, 385); end
                    default: begin px = $urandom_range(0, 1023); py = $urandom_range(0, 511); end
                endcase
                ptd = ($urandom_range(0, 4) != 0);
            end
            if ($urandom_range(0, 49) == 0) btn_mask = 4'($urandom);
            step($urandom_range(0, 299) != 0, $urandom_range(0, 79) != 0,
                 2'($urandom_range(0, 3)), ptd, px, py);
        end
        btn_mask = 4'hF;
        idle_samples(3);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        chk("sb_drain", (sb.size() == 0) ? 4'd0 : 4'd1, 4'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/touch_button_array.md
Name: touch_button_array

Overview:
- Parametrised touch-screen button decoder for N on-screen rectangular buttons.
- Extends the fixed two-button YES/NO hit test with:
  - runtime-programmable rectangles;
  - per-button debounce;
  - press/release event pulses and a held level;
  - an encoded active-button index.
- Sits between the touch-controller coordinate interface (tor_x/tor_y, clcount phase) and the UI/menu control logic.

Parameters:
- N_BTN, 4, number of buttons (1..16).
- X_W, 10, width of tor_x and of rectangle X bounds.
- Y_W, 9, width of tor_y and of rectangle Y bounds.
- SAMPLE_PHASE, 1, clcount value on which a coordinate sample is taken.
- PRESS_CNT, 3, consecutive in-rectangle samples required to declare a press (1..15).
- REL_CNT, 2, consecutive out-of-rectangle or no-touch samples required to declare a release (1..15).

Ports:
- clk, in, 1, system clock; all logic on its rising edge.
- reset, in, 1, asynchronous active-low reset.
- enable, in, 1, block enable; 0 forces the idle state.
- clcount, in, 2, touch-controller phase counter.
- touch_down, in, 1, 1 = the controller reports a valid contact.
- tor_x, in, X_W, touch X coordinate.
- tor_y, in, Y_W, touch Y coordinate.
- rect_x_lo, in, N_BTN*X_W, packed left bounds; button i occupies bits [i*X_W +: X_W].
- rect_x_hi, in, N_BTN*X_W, packed right bounds, inclusive.
- rect_y_lo, in, N_BTN*Y_W, packed top bounds, inclusive.
- rect_y_hi, in, N_BTN*Y_W, packed bottom bounds, inclusive.
- btn_mask, in, N_BTN, 1 = button i is enabled for hit testing.
- btn_hit, out, N_BTN, registered raw one-hot hit of the last sample.
- btn_held, out, N_BTN, debounced one-hot held level.
- btn_press, out, N_BTN, one-clk pulse on press.
- btn_release, out, N_BTN, one-clk pulse on release.
- btn_id, out, 4, index of the held button; valid when any_held=1.
- any_held, out, 1, OR of btn_held.

Behaviour:
- Reset (reset=0, asynchronous): every output = 0, all counters = 0, FSM = IDLE.
- Sample strobe: sample = (clcount == SAMPLE_PHASE). No state changes on non-sample cycles; pulses still clear.
- Hit test, combinational, evaluated on sample: raw[i] = touch_down & btn_mask[i] & x_lo<=tor_x<=x_hi & y_lo<=tor_y<=y_hi.
  - Comparisons are unsigned and inclusive on all four edges.
  - A rectangle with lo > hi never hits.
- Overlap priority: the lowest index with raw=1 wins; btn_hit is one-hot or zero.
- btn_hit is registered on each sample; latency 1 clk after the sample cycle.
- FSM, single active button cur (4 bits) plus counter cnt (4 bits):
  - IDLE: on a sample with any hit, cur <= winner, cnt <= 1, go to ARM. If PRESS_CNT == 1, go directly to HELD and pulse press.
  - ARM: on a sample where the winner == cur, cnt++. When cnt reaches PRESS_CNT: go to HELD, btn_held[cur] <= 1, btn_press[cur] pulses for 1 clk. A sample with a different winner restarts ARM with the new cur and cnt = 1. A sample with no hit goes to IDLE with no pulse.
  - HELD: a sample with winner == cur sets cnt <= 0. Any other sample (miss, no touch, or a different button) increments cnt. When cnt reaches REL_CNT: btn_held[cur] <= 0, btn_release[cur] pulses, go to IDLE. A different button is not armed in the same cycle.
- btn_id = cur and any_held = 1 only in HELD; btn_id = 0 otherwise.
- Press and release pulses never coincide on the same button in one clk.
- enable = 0:
  - From HELD: emits btn_release[cur] once on the next clk, then goes to IDLE.
  - Otherwise: goes to IDLE silently.
  - btn_hit clears on the next clk.
- Masking a held button (btn_mask[cur] -> 0) counts as a miss and follows the normal REL_CNT release.
- Rectangle/mask inputs are sampled combinationally; the host changes them only while not HELD.
- Counters saturate; no wrap-around.
- Reset asserted mid-press clears all outputs with no release pulse.

Test Plan:
- Reset and idle: hold reset=0 with touch active -> all outputs 0. After release with touch_down=0 -> outputs stay 0.
- Basic press/release:
  - Setup: N_BTN=4; btn0 rect x 210..288, y 301..380; touch (250,340) for 3 samples.
  - Required: btn_hit=0001 after the 1st sample; btn_press[0] is one clk after the 3rd sample; btn_held=0001, btn_id=0.
  - Then 2 no-touch samples -> btn_release[0] pulse and btn_held=0.
- Edge inclusivity: touches at (210,301), (288,380) and (406,380) hit btn0, btn0 and btn1 (btn1 rect x 406..495, y 301..380); touches at (209,301) and (289,381) miss everything.
- Debounce bounce: btn1 in, in, out, in, in, in samples -> exactly one press, after the final third consecutive hit. Non-sample clcount values never advance the counters.
- Overlap/mask: btn2 and btn3 both cover (100,100) -> btn_hit=0100 and btn2 is pressed. With btn_mask[2]=0 -> btn3 is pressed.
- Slide and disable: btn0 held, touch slides to btn1 -> btn0 releases after 2 samples and btn1 then arms from cnt=1. enable dropped while held -> single btn_release pulse, then outputs 0.
